mem_io: RTL and testbench



---
 rtl/mem_io.sv | 75 +++++++
 tb/tb_mem_io.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_io.sv
// mem_io: byte-addressed RAM plus memory-mapped output FIFO, status and cycle counter.
`timescale 1ns/1ps
module mem_io #(
  parameter string INIT_FILE = "",
  parameter int    OUT_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic [7:0] to_mem,
  input  logic       mem_write,
  output logic [7:0] from_mem,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);
  localparam int AW = $clog2(OUT_DEPTH);
  logic [7:0]    ram_q  [0:255];
  logic [7:0]    fifo_q [0:OUT_DEPTH-1];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   cyc_q, cyc_d;
  logic [7:0]    snap_q, snap_d;
  logic [7:0]    from_mem_q, from_mem_d;
  logic          empty, full, push, pop, push_ok, ram_we;
  always_comb begin
    empty      = occ_q == '0;
    full       = occ_q == (AW+1)'(OUT_DEPTH);
    pop        = !empty && out_ready;
    push       = mem_write && address == 8'hF0;
    push_ok    = push && (!full || pop);
    ram_we     = mem_write && address <= 8'hEF && !reset;
    wr_ptr_d   = wr_ptr_q + AW'(push_ok);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    occ_d      = occ_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    ovf_d      = (push && full && !pop) ? 1'b1 :
                 (mem_write && address == 8'hF1) ? 1'b0 : ovf_q;
    cyc_d      = (mem_write && address == 8'hF2) ? 16'h0000 : cyc_q + 16'h0001;
    snap_d     = (address == 8'hF2) ? cyc_q[15:8] : snap_q;
    from_mem_d = (address <= 8'hEF) ? ram_q[address] :
                 (address == 8'hF0) ? 8'(occ_q) :
                 (address == 8'hF1) ? {5'b0, ovf_q, empty, full} :
                 (address == 8'hF2) ? cyc_q[7:0] :
                 (address == 8'hF3) ? snap_q : 8'h00;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      ovf_q      <= 1'b0;
      cyc_q      <= 16'h0000;
      snap_q     <= 8'h00;
      from_mem_q <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      ovf_q      <= ovf_d;
      cyc_q      <= cyc_d;
      snap_q     <= snap_d;
      from_mem_q <= from_mem_d;
    end
  end
  always_ff @(posedge clock) begin
    if (ram_we) ram_q[address] <= to_mem;
  end
  always_ff @(posedge clock) begin
    if (push_ok && !reset) fifo_q[wr_ptr_q] <= to_mem;
  end
  assign from_mem  = from_mem_q;
  assign out_data  = fifo_q[rd_ptr_q];
  assign out_valid = !empty;
endmodule

// File: tb/tb_mem_io.sv
// tb_mem_io: randomized scoreboard bench for mem_io against a queue/array reference model.
`timescale 1ns/1ps
module tb_mem_io;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] address = 8'h00;
    logic [7:0] to_mem = 8'h00;
    logic       mem_write = 1'b0;
    logic [7:0] from_mem;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;

    mem_io #(.INIT_FILE(""), .OUT_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .address(address), .to_mem(to_mem),
        .mem_write(mem_write), .from_mem(from_mem), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         ck;
        logic [7:0] rd;
        bit         v;
        logic [7:0] od;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;

    logic [7:0] m_ram [0:255];
    bit         m_known [0:255];
    logic [7:0] fq[$];
    bit         m_ovf = 1'b0;
    logic [15:0] m_cnt = 16'h0000;
    logic [7:0] m_snap = 8'h00;

    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
        end
    endfunction

    // Drive one edge's inputs and predict what the DUT shows right after that edge.
    task automatic step(input bit r, input logic [7:0] a, input logic [7:0] d, input bit w, input bit rdy);
        exp_t e;
        bit popped, was_full;
        @(negedge clock);
        reset = r; address = a; to_mem = d; mem_write = w; out_ready = rdy;
        e.ck = 1'b1;
        if (r) begin
            e.rd = 8'h00;
            fq.delete();
            m_ovf = 1'b0;
            m_cnt = 16'h0000;
            m_snap = 8'h00;
        end else begin
            if (a <= 8'hEF) begin
                e.rd = m_ram[a];
                e.ck = m_known[a];
            end else if (a == 8'hF0) e.rd = 8'(fq.size());
            else if (a == 8'hF1) e.rd = {5'b0, m_ovf, fq.size() == 0, fq.size() == DEPTH};
            else if (a == 8'hF2) e.rd = m_cnt[7:0];
            else if (a == 8'hF3) e.rd = m_snap;
            else e.rd = 8'h00;
            if (a == 8'hF2) m_snap = m_cnt[15:8];
            was_full = fq.size() == DEPTH;
            popped = rdy && fq.size() != 0;
            if (popped) void'(fq.pop_front());
            if (w && a == 8'hF0) begin
                if (was_full && !popped) m_ovf = 1'b1;
                else fq.push_back(d);
            end
            if (w && a == 8'hF1) m_ovf = 1'b0;
            m_cnt = (w && a == 8'hF2) ? 16'h0000 : m_cnt + 16'h0001;
            if (w && a <= 8'hEF) begin
                m_ram[a] = d;
                m_known[a] = 1'b1;
            end
        end
        e.v = fq.size() != 0;
        e.od = e.v ? fq[0] : 8'h00;
        sb.push_back(e);
    endtask

    always @(posedge clock) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.ck) check("from_mem", from_mem, mon_e.rd);
            check("out_valid", {7'b0, out_valid}, {7'b0, mon_e.v});
            if (mon_e.v) check("out_data", out_data, mon_e.od);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        bit w, wrapped;
        int r;
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        step(1, 8'h00, 8'h00, 0, 0);
        step(1, 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < 240; i++) step(0, 8'(i), 8'($urandom), 1, 0);

        // RAM read, then read-before-write on the same address
        step(0, 8'h10, 8'h5A, 1, 0);
        step(0, 8'h10, 8'h00, 0, 0);
        step(0, 8'h10, 8'hA5, 1, 0);
        step(0, 8'h10, 8'h00, 0, 0);

        // fill to full, overflow on the fifth push
        for (int i = 1; i <= 4; i++) step(0, 8'hF0, 8'(i), 1, 0);
        step(0, 8'hF1, 8'h00, 0, 0);
        step(0, 8'hF0, 8'h05, 1, 0);
        step(0, 8'hF1, 8'h00, 0, 0);
        step(0, 8'hF0, 8'h00, 0, 0);

        // drain, then clear overflow
        for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 0, 1);
        step(0, 8'hF1, 8'h00, 0, 0);
        step(0, 8'hF1, 8'h00, 1, 0);
        step(0, 8'hF1, 8'h00, 0, 0);

        // push and pop together while full
        for (int i = 1; i <= 4; i++) step(0, 8'hF0, 8'(8'h30 + i), 1, 0);
        step(0, 8'hF0, 8'h77, 1, 1);
        step(0, 8'hF0, 8'h00, 0, 0);
        step(0, 8'hF1, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 0, 1);

        // reset with three queued bytes, overflow set and a RAM write pending
        for (int i = 1; i <= 5; i++) step(0, 8'hF0, 8'(8'h40 + i), 1, 0);
        step(0, 8'h00, 8'h00, 0, 1);
        step(1, 8'h20, 8'hEE, 1, 1);
        step(0, 8'hF1, 8'h00, 0, 0);
        step(0, 8'hF2, 8'h00, 0, 0);
        step(0, 8'h20, 8'h00, 0, 0);

        // counter: clear, snapshot at 0x12FF, then run through the 16-bit wrap
        step(0, 8'hF2, 8'h00, 1, 0);
        wrapped = 1'b0;
        for (int i = 0; i < 70000 && !wrapped; i++) begin
            if (m_cnt == 16'h12FF) begin
                step(0, 8'hF2, 8'h00, 0, 0);
                step(0, 8'hF3, 8'h00, 0, 0);
            end else if (m_cnt == 16'hFFFF) begin
                step(0, 8'hF2, 8'h00, 0, 0);
                step(0, 8'hF2, 8'h00, 0, 0);
                step(0, 8'hF3, 8'h00, 0, 0);
                wrapped = 1'b1;
            end else begin
                r = $urandom_range(0, 9);
                a = (r < 6) ? 8'($urandom_range(0, 239)) : (r < 8) ? 8'hF0 :
                    (r == 8) ? 8'hF1 : 8'($urandom_range(242, 255));
                w = $urandom_range(0, 1) == 1 && a != 8'hF2;
                step(0, a, 8'($urandom), w, $urandom_range(0, 7) < ((i >> 10) & 7));
            end
        end
        @(posedge clock);
        #2;
        checks++;
        if (sb.size() != 0 || !wrapped) begin
            errors++;
            $display("FAIL drain: %0d expectations left, wrapped=%0d", sb.size(), wrapped);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
